operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Requester side of the register access interface: takes decoded instructions, drives rs1/rs2 read addresses, captures returned operand data and presents a one-entry operand bundle to execute.
- Maintains a pending-write scoreboard for RAW/WAW hazards and bypasses same-cycle writeback data.
- Sits between decode and execute in the RV32I pipeline; its register-file side connects directly to the register access interface.

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register address width
- NUM_REGS, 32, architectural register count
- STALL_CNT_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- halt  in  1  freeze: no accept, no issue; outputs hold
- flush  in  1  drop held bundle and block decode acceptance this cycle
- dec_valid  in  1  decoded instruction valid
- dec_ready  out  1  stage accepts decoded instruction
- dec_opcode  in  7  opcode
- dec_funct3  in  3  funct3
- dec_rs1_addr / dec_rs2_addr / dec_rd_addr  in  REG_ADDR_W each  operand and destination addresses
- dec_uses_rs1 / dec_uses_rs2 / dec_writes_rd  in  1 each  operand usage flags
- rf_rs1_addr / rf_rs2_addr  out  REG_ADDR_W each  register read addresses, combinational from dec_rs*_addr
- rf_rs1_data / rf_rs2_data  in  XLEN each  combinational read data
- wb_valid  in  1  writeback this cycle
- wb_rd_addr  in  REG_ADDR_W  writeback destination
- wb_data  in  XLEN  writeback value
- op_valid  out  1  operand bundle valid
- op_ready  in  1  execute accepts bundle
- op_rs1_data / op_rs2_data  out  XLEN each  resolved operands
- op_rd_addr  out  REG_ADDR_W  destination
- op_writes_rd  out  1  destination flag
- op_opcode  out  7, op_funct3  out  3  passed through
- stall_count  out  STALL_CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (async, rst_n=0): op_valid=0, all op_* data/address outputs 0, scoreboard all 0, stall_count=0. dec_ready is combinational and evaluates to 1 after reset when halt=0 and flush=0.
- Output register state: EMPTY (op_valid=0) or FULL (op_valid=1).
- FULL->EMPTY on op_ready with no new accept.
- EMPTY->FULL on accept.
- FULL->FULL on op_ready together with an accept, or while op_ready=0 (bundle held stable).
- Hazard: rs1 hazard = dec_uses_rs1 && rs1!=0 && pend[rs1] && !(wb_valid && wb_rd_addr==rs1). rs2 hazard is the same form. WAW hazard = dec_writes_rd && rd!=0 && pend[rd] && !(wb_valid && wb_rd_addr==rd).
- dec_ready = !halt && !flush && !hazard && (!op_valid || op_ready).
- Accept = dec_valid && dec_ready. Latency is 1 cycle: the bundle appears on op_* the cycle after accept.
- Operand resolution at accept:
  - addr==0 -> 0.
  - else wb_valid && wb_rd_addr==addr -> wb_data (bypass).
  - else rf data.
  - Unused operands still capture the resolved value.
- Scoreboard: pend[0] is hardwired 0.
  - wb_valid clears pend[wb_rd_addr].
  - Accept with dec_writes_rd and rd!=0 sets pend[rd].
  - Set and clear on the same index in the same cycle: set wins.
- flush:
  - op_valid -> 0 next cycle.
  - If the held bundle has op_writes_rd and op_rd_addr!=0, clear its pend bit (safe because WAW stalls guarantee no older writer).
  - Simultaneous wb clear is unaffected.
  - flush overrides op_ready.
- halt: no accept, op_* hold, scoreboard still clears on wb_valid. flush takes priority over halt.
- stall_count increments when dec_valid && hazard && !halt && !flush, saturating at all-ones.
- Reset mid-operation: everything returns to reset values immediately. No pending state survives.

Decomposition:
- Shared package/header: XLEN, REG_ADDR_W, opcode/funct3 widths and the op-bundle field layout, added alongside the existing rv_32i definitions.
- One sub-module: op_scoreboard, holding the pending vector with set/clear/flush-clear ports and the combinational hazard lookup.

Test Plan:
- Reset, then accept ADDI x5 (rs1=x1, rf=0x10) -> op_valid=1 next cycle, op_rs1_data=0x10, pend[5]=1.
- Consumer of x5 while pend[5]=1, no wb -> dec_ready=0, stall_count increments each cycle. wb_valid with x5=0xABCD -> accept that cycle, op_rs1_data=0xABCD (bypass).
- Read rs1=x0 while rf_rs1_data=0xFFFFFFFF -> op_rs1_data=0. Writer with rd=x0 -> pend unchanged.
- op_ready=0 for 3 cycles with dec_valid=1 -> bundle held stable, dec_ready=0. op_ready=1 -> next instruction captured the same cycle.
- Accept writer rd=x7, then flush -> op_valid=0 and pend[7]=0 next cycle. Same-cycle wb_valid to x7 plus an accept writing x7 -> pend[7]=1.
- Assert rst_n=0 with FULL and pend bits set -> op_valid=0, stall_count=0, scoreboard all 0 without waiting for a clock edge.

Source files
------------

// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths, output-state encoding, operand bundle layout and operand
// resolution helper for the operand fetch stage.
package operand_fetch_stage_pkg;

  localparam int XLEN        = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int NUM_REGS    = 32;
  localparam int STALL_CNT_W = 16;
  localparam int OPCODE_W    = 7;
  localparam int FUNCT3_W    = 3;

  typedef enum logic {
    OB_EMPTY = 1'b0,
    OB_FULL  = 1'b1
  } ob_state_e;

  typedef struct packed {
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  writes_rd;
    logic [OPCODE_W-1:0]   opcode;
    logic [FUNCT3_W-1:0]   funct3;
  } op_bundle_t;

  // x0 reads as zero; a same-cycle writeback beats the register file value.
  function automatic logic [XLEN-1:0] resolve_operand(
    input logic [REG_ADDR_W-1:0] addr,
    input logic                  wb_valid,
    input logic [REG_ADDR_W-1:0] wb_addr,
    input logic [XLEN-1:0]       wb_data,
    input logic [XLEN-1:0]       rf_data
  );
    logic [XLEN-1:0] res;
    if (addr == '0) begin
      res = '0;
    end else if (wb_valid && (wb_addr == addr)) begin
      res = wb_data;
    end else begin
      res = rf_data;
    end
    return res;
  endfunction

endpackage

// File: rtl/operand_fetch_stage_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, with
// writeback clear, flush clear, accept set and combinational hazard lookup.
module op_scoreboard #(
  parameter int NUM_REGS   = operand_fetch_stage_pkg::NUM_REGS,
  parameter int REG_ADDR_W = operand_fetch_stage_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic                  fclr_en,
  input  logic [REG_ADDR_W-1:0] fclr_addr,
  input  logic                  uses_rs1,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic                  uses_rs2,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  writes_rd,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  hazard
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic                rs1_haz;
  logic                rs2_haz;
  logic                waw_haz;

  // A register being written back this cycle is no longer a hazard.
  function automatic logic busy(
    input logic [NUM_REGS-1:0]   vec,
    input logic [REG_ADDR_W-1:0] addr,
    input logic                  wb_en,
    input logic [REG_ADDR_W-1:0] wb_addr
  );
    return (addr != '0) && vec[addr] && !(wb_en && (wb_addr == addr));
  endfunction

  assign rs1_haz = uses_rs1  && busy(pend_q, rs1_addr, clr_en, clr_addr);
  assign rs2_haz = uses_rs2  && busy(pend_q, rs2_addr, clr_en, clr_addr);
  assign waw_haz = writes_rd && busy(pend_q, rd_addr,  clr_en, clr_addr);
  assign hazard  = rs1_haz || rs2_haz || waw_haz;

  always_comb begin
    pend_d = pend_q;
    if (clr_en) begin
      pend_d[clr_addr] = 1'b0;
    end
    if (fclr_en) begin
      pend_d[fclr_addr] = 1'b0;
    end
    // Set is applied last so it wins over a same-index clear.
    if (set_en) begin
      pend_d[set_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: accepts decoded instructions, reads/bypasses operands,
// tracks pending writes and holds a one-entry operand bundle for execute.
module operand_fetch_stage #(
  parameter int XLEN        = operand_fetch_stage_pkg::XLEN,
  parameter int REG_ADDR_W  = operand_fetch_stage_pkg::REG_ADDR_W,
  parameter int NUM_REGS    = operand_fetch_stage_pkg::NUM_REGS,
  parameter int STALL_CNT_W = operand_fetch_stage_pkg::STALL_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   halt,
  input  logic                   flush,
  input  logic                   dec_valid,
  output logic                   dec_ready,
  input  logic [6:0]             dec_opcode,
  input  logic [2:0]             dec_funct3,
  input  logic [REG_ADDR_W-1:0]  dec_rs1_addr,
  input  logic [REG_ADDR_W-1:0]  dec_rs2_addr,
  input  logic [REG_ADDR_W-1:0]  dec_rd_addr,
  input  logic                   dec_uses_rs1,
  input  logic                   dec_uses_rs2,
  input  logic                   dec_writes_rd,
  output logic [REG_ADDR_W-1:0]  rf_rs1_addr,
  output logic [REG_ADDR_W-1:0]  rf_rs2_addr,
  input  logic [XLEN-1:0]        rf_rs1_data,
  input  logic [XLEN-1:0]        rf_rs2_data,
  input  logic                   wb_valid,
  input  logic [REG_ADDR_W-1:0]  wb_rd_addr,
  input  logic [XLEN-1:0]        wb_data,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [XLEN-1:0]        op_rs1_data,
  output logic [XLEN-1:0]        op_rs2_data,
  output logic [REG_ADDR_W-1:0]  op_rd_addr,
  output logic                   op_writes_rd,
  output logic [6:0]             op_opcode,
  output logic [2:0]             op_funct3,
  output logic [STALL_CNT_W-1:0] stall_count
);

  import operand_fetch_stage_pkg::*;

  ob_state_e              state_q;
  ob_state_e              state_d;
  op_bundle_t             bundle_q;
  op_bundle_t             bundle_d;
  logic [STALL_CNT_W-1:0] stall_q;
  logic [STALL_CNT_W-1:0] stall_d;
  logic                   hazard;
  logic                   accept;
  logic                   stall_inc;
  logic                   sb_set_en;
  logic                   sb_fclr_en;

  assign rf_rs1_addr = dec_rs1_addr;
  assign rf_rs2_addr = dec_rs2_addr;

  assign op_valid  = (state_q == OB_FULL);
  assign dec_ready = !halt && !flush && !hazard && (!op_valid || op_ready);
  assign accept    = dec_valid && dec_ready;

  assign sb_set_en  = accept && dec_writes_rd && (dec_rd_addr != '0);
  // Dropping a held writer is safe: WAW stalls mean no older write to that rd.
  assign sb_fclr_en = flush && op_valid && bundle_q.writes_rd && (bundle_q.rd_addr != '0);

  op_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (sb_set_en),
    .set_addr  (dec_rd_addr),
    .clr_en    (wb_valid),
    .clr_addr  (wb_rd_addr),
    .fclr_en   (sb_fclr_en),
    .fclr_addr (bundle_q.rd_addr),
    .uses_rs1  (dec_uses_rs1),
    .rs1_addr  (dec_rs1_addr),
    .uses_rs2  (dec_uses_rs2),
    .rs2_addr  (dec_rs2_addr),
    .writes_rd (dec_writes_rd),
    .rd_addr   (dec_rd_addr),
    .hazard    (hazard)
  );

  always_comb begin
    state_d  = state_q;
    bundle_d = bundle_q;
    if (flush) begin
      state_d = OB_EMPTY;
    end else begin
      unique case (state_q)
        OB_EMPTY: if (accept) state_d = OB_FULL;
        OB_FULL:  if (!halt && op_ready && !accept) state_d = OB_EMPTY;
        default:  state_d = OB_EMPTY;
      endcase
    end
    if (accept) begin
      bundle_d.rs1_data  = resolve_operand(dec_rs1_addr, wb_valid, wb_rd_addr, wb_data, rf_rs1_data);
      bundle_d.rs2_data  = resolve_operand(dec_rs2_addr, wb_valid, wb_rd_addr, wb_data, rf_rs2_data);
      bundle_d.rd_addr   = dec_rd_addr;
      bundle_d.writes_rd = dec_writes_rd;
      bundle_d.opcode    = dec_opcode;
      bundle_d.funct3    = dec_funct3;
    end
  end

  assign stall_inc = dec_valid && hazard && !halt && !flush;

  always_comb begin
    stall_d = stall_q;
    if (stall_inc && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OB_EMPTY;
      bundle_q <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      bundle_q <= bundle_d;
      stall_q  <= stall_d;
    end
  end

  assign op_rs1_data  = bundle_q.rs1_data;
  assign op_rs2_data  = bundle_q.rs2_data;
  assign op_rd_addr   = bundle_q.rd_addr;
  assign op_writes_rd = bundle_q.writes_rd;
  assign op_opcode    = bundle_q.opcode;
  assign op_funct3    = bundle_q.funct3;
  assign stall_count  = stall_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed scenarios plus
// randomized traffic against a behavioural pipeline/scoreboard model.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt, flush;
  logic        dec_valid, dec_ready;
  logic [6:0]  dec_opcode;
  logic [2:0]  dec_funct3;
  logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
  logic        dec_uses_rs1, dec_uses_rs2, dec_writes_rd;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        op_valid, op_ready;
  logic [31:0] op_rs1_data, op_rs2_data;
  logic [4:0]  op_rd_addr;
  logic        op_writes_rd;
  logic [6:0]  op_opcode;
  logic [2:0]  op_funct3;
  logic [15:0] stall_count;

  logic [31:0] rf_mem [32];
  assign rf_rs1_data = rf_mem[rf_rs1_addr];
  assign rf_rs2_data = rf_mem[rf_rs2_addr];

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_opcode(dec_opcode), .dec_funct3(dec_funct3),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr), .dec_rd_addr(dec_rd_addr),
    .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2), .dec_writes_rd(dec_writes_rd),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data),
    .op_rd_addr(op_rd_addr), .op_writes_rd(op_writes_rd),
    .op_opcode(op_opcode), .op_funct3(op_funct3),
    .stall_count(stall_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: set of registers with an outstanding write, plus the
  // single bundle execute would currently see.
  bit          m_pend [32];
  bit          m_valid;
  logic [31:0] m_rs1, m_rs2;
  logic [4:0]  m_rd;
  bit          m_wr;
  logic [6:0]  m_opc;
  logic [2:0]  m_f3;
  int          m_stall;

  function automatic bit m_busy(input logic [4:0] a);
    return (a != 0) && m_pend[a] && !(wb_valid && wb_rd_addr == a);
  endfunction

  function automatic bit m_hazard();
    return (dec_uses_rs1 && m_busy(dec_rs1_addr)) || (dec_uses_rs2 && m_busy(dec_rs2_addr))
        || (dec_writes_rd && m_busy(dec_rd_addr));
  endfunction

  function automatic bit m_ready();
    return !halt && !flush && !m_hazard() && (!m_valid || op_ready);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_valid && wb_rd_addr == a) return wb_data;
    return rf_mem[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_wr = 0; m_opc = 0; m_f3 = 0; m_stall = 0;
  endtask

  task automatic model_edge();
    bit acc;
    acc = dec_valid && m_ready();
    if (dec_valid && m_hazard() && !halt && !flush && m_stall < 65535) m_stall++;
    if (wb_valid) m_pend[wb_rd_addr] = 1'b0;
    if (flush && m_valid && m_wr && m_rd != 0) m_pend[m_rd] = 1'b0;
    if (acc && dec_writes_rd && dec_rd_addr != 0) m_pend[dec_rd_addr] = 1'b1;
    if (flush) begin
      m_valid = 0;
    end else if (acc) begin
      m_rs1 = m_read(dec_rs1_addr); m_rs2 = m_read(dec_rs2_addr);
      m_rd = dec_rd_addr; m_wr = dec_writes_rd; m_opc = dec_opcode; m_f3 = dec_funct3;
      m_valid = 1;
    end else if (!halt && m_valid && op_ready) begin
      m_valid = 0;
    end
    if (wb_valid && wb_rd_addr != 0) rf_mem[wb_rd_addr] = wb_data;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    halt = 0; flush = 0; dec_valid = 0; dec_opcode = 0; dec_funct3 = 0;
    dec_rs1_addr = 0; dec_rs2_addr = 0; dec_rd_addr = 0;
    dec_uses_rs1 = 0; dec_uses_rs2 = 0; dec_writes_rd = 0;
    wb_valid = 0; wb_rd_addr = 0; wb_data = 0; op_ready = 1;
  endtask

  task automatic set_dec(input logic [6:0] opc, input logic [2:0] f3,
                         input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2,
                         input logic [4:0] rd, input bit wr);
    dec_valid = 1; dec_opcode = opc; dec_funct3 = f3;
    dec_rs1_addr = rs1; dec_uses_rs1 = u1; dec_rs2_addr = rs2; dec_uses_rs2 = u2;
    dec_rd_addr = rd; dec_writes_rd = wr;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_clear();
    #2;
    n_tests++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_op_valid got %b exp 0", op_valid); end
    n_tests++; if (op_rs1_data !== 32'h0 || op_rs2_data !== 32'h0 || op_rd_addr !== 5'h0)
      begin n_fail++; $display("FAIL reset_op_data got %h %h %h exp 0", op_rs1_data, op_rs2_data, op_rd_addr); end
    n_tests++; if (stall_count !== 16'h0) begin n_fail++; $display("FAIL reset_stall got %h exp 0", stall_count); end
    n_tests++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL reset_dec_ready got %b exp 1", dec_ready); end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_addi();
    idle_inputs();
    rf_mem[1] = 32'h10;
    set_dec(7'h13, 3'd0, 5'd1, 1, 5'd0, 0, 5'd5, 1);
    #1;
    n_tests++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL addi_ready got %b exp 1", dec_ready); end
    n_tests++; if (rf_rs1_addr !== 5'd1) begin n_fail++; $display("FAIL addi_rf_addr got %0d exp 1", rf_rs1_addr); end
    tick();
    dec_valid = 0;
    n_tests++; if (op_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %b exp 1", op_valid); end
    n_tests++; if (op_rs1_data !== 32'h10) begin n_fail++; $display("FAIL addi_rs1 got %h exp 00000010", op_rs1_data); end
    n_tests++; if (op_rd_addr !== 5'd5 || op_writes_rd !== 1'b1 || op_opcode !== 7'h13)
      begin n_fail++; $display("FAIL addi_fields got rd=%0d wr=%b opc=%h exp 5 1 13", op_rd_addr, op_writes_rd, op_opcode); end
  endtask

  task automatic test_raw_bypass();
    rf_mem[5] = 32'h5555_5555;
    set_dec(7'h33, 3'd0, 5'd5, 1, 5'd0, 0, 5'd6, 1);
    for (int k = 1; k <= 3; k++) begin
      #1;
      n_tests++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_ready got %b exp 0", dec_ready); end
      tick();
      n_tests++; if (stall_count !== 16'(k)) begin n_fail++; $display("FAIL raw_stall_count got %0d exp %0d", stall_count, k); end
    end
    wb_valid = 1; wb_rd_addr = 5'd5; wb_data = 32'hABCD;
    #1;
    n_tests++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL bypass_ready got %b exp 1", dec_ready); end
    tick();
    idle_inputs();
    n_tests++; if (op_rs1_data !== 32'hABCD) begin n_fail++; $display("FAIL bypass_rs1 got %h exp 0000abcd", op_rs1_data); end
    n_tests++; if (stall_count !== 16'd3) begin n_fail++; $display("FAIL bypass_stall got %0d exp 3", stall_count); end
  endtask

  task automatic test_x0();
    rf_mem[0] = 32'hFFFF_FFFF;
    set_dec(7'h13, 3'd0, 5'd0, 1, 5'd0, 1, 5'd0, 1);
    #1;
    n_tests++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready got %b exp 1", dec_ready); end
    tick();
    n_tests++; if (op_rs1_data !== 32'h0 || op_rs2_data !== 32'h0)
      begin n_fail++; $display("FAIL x0_operands got %h %h exp 0", op_rs1_data, op_rs2_data); end
    #1;
    n_tests++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL x0_no_pend got %b exp 1", dec_ready); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    rf_mem[2] = 32'h1111; rf_mem[3] = 32'h2222; rf_mem[4] = 32'h4444;
    set_dec(7'h33, 3'd0, 5'd2, 1, 5'd3, 1, 5'd9, 1);
    tick();
    op_ready = 0;
    set_dec(7'h13, 3'd2, 5'd4, 1, 5'd0, 0, 5'd10, 1);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready got %b exp 0", dec_ready); end
      tick();
      n_tests++; if (op_valid !== 1'b1 || op_rs1_data !== 32'h1111 || op_rs2_data !== 32'h2222 || op_rd_addr !== 5'd9)
        begin n_fail++; $display("FAIL bp_hold got v=%b %h %h rd=%0d exp 1 1111 2222 9", op_valid, op_rs1_data, op_rs2_data, op_rd_addr); end
    end
    op_ready = 1;
    #1;
    n_tests++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", dec_ready); end
    tick();
    idle_inputs();
    n_tests++; if (op_valid !== 1'b1 || op_rs1_data !== 32'h4444 || op_rd_addr !== 5'd10 || op_funct3 !== 3'd2)
      begin n_fail++; $display("FAIL bp_next got v=%b %h rd=%0d f3=%0d exp 1 4444 10 2", op_valid, op_rs1_data, op_rd_addr, op_funct3); end
    tick();
  endtask

  task automatic test_flush();
    set_dec(7'h13, 3'd0, 5'd0, 0, 5'd0, 0, 5'd7, 1);
    tick();
    idle_inputs();
    flush = 1; op_ready = 0;
    tick();
    flush = 0;
    n_tests++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", op_valid); end
    set_dec(7'h33, 3'd0, 5'd7, 1, 5'd0, 0, 5'd0, 0);
    #1;
    n_tests++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL flush_pend_clear got %b exp 1", dec_ready); end
    tick();
    op_ready = 1;
    set_dec(7'h13, 3'd0, 5'd0, 0, 5'd0, 0, 5'd7, 1);
    wb_valid = 1; wb_rd_addr = 5'd7; wb_data = 32'h77;
    tick();
    wb_valid = 0;
    set_dec(7'h33, 3'd0, 5'd7, 1, 5'd0, 0, 5'd0, 0);
    #1;
    n_tests++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL set_wins got %b exp 0", dec_ready); end
  endtask

  task automatic test_mid_reset();
    op_ready = 0;
    tick();
    #2;
    rst_n = 0;
    model_clear();
    #1;
    n_tests++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got %b exp 0", op_valid); end
    n_tests++; if (stall_count !== 16'h0) begin n_fail++; $display("FAIL mid_reset_stall got %0d exp 0", stall_count); end
    op_ready = 1;
    #1;
    n_tests++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_pend got %b exp 1", dec_ready); end
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      halt = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 15) == 0);
      dec_valid = ($urandom_range(0, 9) < 7);
      dec_opcode = 7'($urandom); dec_funct3 = 3'($urandom);
      dec_rs1_addr = 5'($urandom_range(0, 7)); dec_rs2_addr = 5'($urandom_range(0, 7));
      dec_rd_addr = 5'($urandom_range(0, 7));
      dec_uses_rs1 = 1'($urandom); dec_uses_rs2 = 1'($urandom); dec_writes_rd = 1'($urandom);
      wb_valid = ($urandom_range(0, 9) < 4);
      wb_rd_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
      op_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) rf_mem[$urandom_range(1, 7)] = $urandom;
      #1;
      n_tests++; if (dec_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %b exp %b", c, dec_ready, m_ready()); end
      n_tests++; if (rf_rs2_addr !== dec_rs2_addr) begin n_fail++; $display("FAIL rnd_rf_addr cyc %0d got %0d exp %0d", c, rf_rs2_addr, dec_rs2_addr); end
      tick();
      n_tests++; if (op_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, op_valid, m_valid); end
      if (m_valid) begin
        n_tests++;
        if (op_rs1_data !== m_rs1 || op_rs2_data !== m_rs2 || op_rd_addr !== m_rd ||
            op_writes_rd !== m_wr || op_opcode !== m_opc || op_funct3 !== m_f3) begin
          n_fail++;
          $display("FAIL rnd_bundle cyc %0d got %h %h %0d %b %h %0d exp %h %h %0d %b %h %0d", c,
                   op_rs1_data, op_rs2_data, op_rd_addr, op_writes_rd, op_opcode, op_funct3,
                   m_rs1, m_rs2, m_rd, m_wr, m_opc, m_f3);
        end
      end
      n_tests++; if (stall_count !== 16'(m_stall)) begin n_fail++; $display("FAIL rnd_stall cyc %0d got %0d exp %0d", c, stall_count, m_stall); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_stall_saturate();
    idle_inputs();
    wb_valid = 1; wb_rd_addr = 5'd3; wb_data = 32'h0;
    tick();
    wb_valid = 0;
    set_dec(7'h13, 3'd0, 5'd0, 0, 5'd0, 0, 5'd3, 1);
    tick();
    set_dec(7'h33, 3'd0, 5'd3, 1, 5'd0, 0, 5'd0, 0);
    repeat (65600) tick();
    n_tests++; if (stall_count !== 16'hFFFF) begin n_fail++; $display("FAIL stall_saturate got %h exp ffff", stall_count); end
    n_tests++; if (stall_count !== 16'(m_stall)) begin n_fail++; $display("FAIL stall_model got %0d exp %0d", stall_count, m_stall); end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
    rst_n = 0;
    idle_inputs();
    model_clear();
    @(posedge clk); #1;
    test_reset();
    test_addi();
    test_raw_bypass();
    test_x0();
    test_backpressure();
    test_flush();
    test_mid_reset();
    test_random();
    test_stall_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
